outpkt_commit_fifo: RTL and testbench

OUTPKT_COMMIT_FIFO -- requirements
Module: outpkt_commit_fifo

---
 rtl/outpkt_commit_fifo_pkg.sv | 15 +
 rtl/outpkt_commit_ram.sv | 37 +++
 rtl/outpkt_commit_fifo.sv | 96 +++++++++
 tb/tb_outpkt_commit_fifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/outpkt_commit_fifo_pkg.sv
// Shared pkt_comm definitions for the output packet path: default RAM geometry,
// maximum packet length and the stored RAM entry layout.
package outpkt_commit_fifo_pkg;

    localparam int PKT_COMM_ADDR_MSB = 9;
    localparam int PKT_COMM_DEPTH    = 1 << (PKT_COMM_ADDR_MSB + 1);
    localparam int PKT_COMM_MAX_LEN  = PKT_COMM_DEPTH - 1;
    localparam int PKT_COMM_WORD_W   = 16;

    typedef struct packed {
        logic                       pkt_end;
        logic [PKT_COMM_WORD_W-1:0] word;
    } ram_entry_t;

endpackage

// File: rtl/outpkt_commit_ram.sv
// Simple dual-port packet RAM: one write port, one read port with read-enable
// and a registered output that clears on reset.
module outpkt_commit_ram
    import outpkt_commit_fifo_pkg::*;
#(
    parameter int ADDR_MSB = PKT_COMM_ADDR_MSB
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDR_MSB:0] wr_addr,
    input  ram_entry_t       wr_data,
    input  logic             rd_en,
    input  logic [ADDR_MSB:0] rd_addr,
    output ram_entry_t       rd_data
);

    localparam int DEPTH = 1 << (ADDR_MSB + 1);

    ram_entry_t mem [0:DEPTH-1];

    // NOTE: the array itself is never reset so it maps onto block RAM; only the read register is.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/outpkt_commit_fifo.sv
// Packet-commit FIFO: words become visible to the consumer only once the
// packet's last word has been written, and committed packets are counted.
module outpkt_commit_fifo
    import outpkt_commit_fifo_pkg::*;
#(
    parameter int ADDR_MSB = PKT_COMM_ADDR_MSB,
    parameter int CNT_MSB  = 7
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic [PKT_COMM_WORD_W-1:0] din,
    input  logic                       din_pkt_end,
    input  logic                       din_empty,
    output logic                       din_rd_en,
    output logic [PKT_COMM_WORD_W-1:0] dout,
    output logic                       dout_pkt_end,
    input  logic                       rd_en,
    output logic                       empty,
    output logic [CNT_MSB:0]           pkt_count
);

    localparam int                MAX_PKT_LEN = (1 << (ADDR_MSB + 1)) - 1;
    localparam logic [ADDR_MSB:0] PTR_ONE     = 1;
    localparam logic [CNT_MSB:0]  CNT_ONE     = 1;
    localparam logic [CNT_MSB:0]  CNT_MAX     = '1;

    logic [ADDR_MSB:0] wr_ptr, wr_ptr_inc, commit_ptr, rd_ptr;
    logic              ram_full, commit, fetch, valid, pop_last;
    ram_entry_t        wr_entry, rd_entry;

    assign wr_ptr_inc = wr_ptr + PTR_ONE;
    assign ram_full   = (wr_ptr_inc == rd_ptr);
    assign din_rd_en  = ~rst & ~din_empty & ~ram_full;
    assign commit     = din_rd_en & din_pkt_end;

    // Only words below commit_ptr are fetched, hiding partially written packets.
    assign fetch    = (rd_ptr != commit_ptr) & (~valid | rd_en);
    assign pop_last = valid & rd_en & rd_entry.pkt_end;

    assign wr_entry     = '{pkt_end: din_pkt_end, word: din};
    assign empty        = ~valid;
    assign dout         = rd_entry.word;
    assign dout_pkt_end = rd_entry.pkt_end;

    outpkt_commit_ram #(
        .ADDR_MSB (ADDR_MSB)
    ) u_ram (
        .CLK     (CLK),
        .rst     (rst),
        .wr_en   (din_rd_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (fetch),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            valid      <= 1'b0;
        end else begin
            if (din_rd_en) wr_ptr     <= wr_ptr_inc;
            if (commit)    commit_ptr <= wr_ptr_inc;
            if (fetch)     rd_ptr     <= rd_ptr + PTR_ONE;
            valid <= fetch | (valid & ~rd_en);
        end
    end

    // A commit and a final-word pop in the same cycle cancel out.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            case ({commit, pop_last})
                2'b10:   if (pkt_count != CNT_MAX) pkt_count <= pkt_count + CNT_ONE;
                2'b01:   if (pkt_count != '0)      pkt_count <= pkt_count - CNT_ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A full RAM holding no committed word can never drain: the packet is too long.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            assert (!(ram_full && (rd_ptr == commit_ptr)))
                else $error("outpkt_commit_fifo: packet longer than %0d words", MAX_PKT_LEN);
        end
    end
`endif

endmodule

// File: tb/tb_outpkt_commit_fifo.sv
// Directed bench for outpkt_commit_fifo: a vector table for single-cycle
// behaviour plus sequences for partial packets, fill, saturation, wrap and reset.
module tb_outpkt_commit_fifo;

    logic        CLK = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_pkt_end;
    logic        din_empty;
    logic        din_rd_en;
    logic [15:0] dout;
    logic        dout_pkt_end;
    logic        rd_en;
    logic        empty;
    logic [7:0]  pkt_count;

    int n_cmp = 0;
    int n_bad = 0;

    outpkt_commit_fifo dut (
        .CLK          (CLK),
        .rst          (rst),
        .din          (din),
        .din_pkt_end  (din_pkt_end),
        .din_empty    (din_empty),
        .din_rd_en    (din_rd_en),
        .dout         (dout),
        .dout_pkt_end (dout_pkt_end),
        .rd_en        (rd_en),
        .empty        (empty),
        .pkt_count    (pkt_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [15:0] din;
        logic        pe;
        logic        de;
        logic        rd;
        logic        exp_rd_en;
        logic        exp_empty;
        logic        chk_dout;
        logic [15:0] exp_dout;
        logic        exp_pe;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din = '0; din_pkt_end = 1'b0; din_empty = 1'b1; rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] w, input logic pe);
        din = w; din_pkt_end = pe; din_empty = 1'b0;
        #1;
        check("push_din_rd_en", din_rd_en, 1'b1);
        tick();
        din_empty = 1'b1; din_pkt_end = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [15:0] w, input logic pe);
        check({name, "_empty"}, empty, 1'b0);
        check({name, "_dout"}, dout, w);
        check({name, "_pkt_end"}, dout_pkt_end, pe);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    function automatic logic fill_pe(input int i);
        return (i == 340) || (i == 681) || (i == 1023);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        int          errs;
        int          k;
        int          popped;
        int          mcnt;
        logic        acc_now;
        logic [16:0] exp_e;
        logic [16:0] q [$];

        // rst, din, pe, de, rd | rd_en, empty, chk_dout, dout, pkt_end, count
        vecs[0]  = '{1, 16'h0000, 0, 1, 0,  0, 1, 1, 16'h0000, 0, 0};
        vecs[1]  = '{0, 16'h01D2, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 0};
        vecs[2]  = '{0, 16'h0002, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 0};
        vecs[3]  = '{0, 16'h0003, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 0};
        vecs[4]  = '{0, 16'h0004, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 0};
        vecs[5]  = '{0, 16'h0005, 1, 0, 0,  1, 1, 0, 16'h0000, 0, 1};
        vecs[6]  = '{0, 16'h0000, 0, 1, 0,  0, 0, 1, 16'h01D2, 0, 1};
        vecs[7]  = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0002, 0, 1};
        vecs[8]  = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0003, 0, 1};
        vecs[9]  = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0004, 0, 1};
        vecs[10] = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0005, 1, 1};
        vecs[11] = '{0, 16'h0000, 0, 1, 1,  0, 1, 0, 16'h0000, 0, 0};
        vecs[12] = '{0, 16'h0000, 0, 1, 1,  0, 1, 0, 16'h0000, 0, 0};
        // packet A (2 words) then B, B committed while A's last word is popped
        vecs[13] = '{0, 16'h0A01, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 0};
        vecs[14] = '{0, 16'h0A02, 1, 0, 0,  1, 1, 0, 16'h0000, 0, 1};
        vecs[15] = '{0, 16'h0B01, 0, 0, 0,  1, 0, 1, 16'h0A01, 0, 1};
        vecs[16] = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0A02, 1, 1};
        vecs[17] = '{0, 16'h0B02, 1, 0, 1,  1, 1, 0, 16'h0000, 0, 1};
        vecs[18] = '{0, 16'h0000, 0, 1, 0,  0, 0, 1, 16'h0B01, 0, 1};
        vecs[19] = '{0, 16'h0000, 0, 1, 1,  0, 0, 1, 16'h0B02, 1, 1};
        vecs[20] = '{0, 16'h0000, 0, 1, 1,  0, 1, 0, 16'h0000, 0, 0};

        for (int i = 0; i < 21; i++) begin
            rst = vecs[i].rst; din = vecs[i].din; din_pkt_end = vecs[i].pe;
            din_empty = vecs[i].de; rd_en = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_din_rd_en", i), din_rd_en, vecs[i].exp_rd_en);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
            check($sformatf("vec%0d_pkt_count", i), pkt_count, vecs[i].exp_cnt);
            if (vecs[i].chk_dout) begin
                check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
                check($sformatf("vec%0d_dout_pkt_end", i), dout_pkt_end, vecs[i].exp_pe);
            end
        end
        din_empty = 1'b1; rd_en = 1'b0; din_pkt_end = 1'b0;

        // Partial packet stays hidden until its last word arrives.
        push(16'h0C01, 1'b0);
        push(16'h0C02, 1'b0);
        push(16'h0C03, 1'b0);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (empty !== 1'b1 || pkt_count !== 8'd0) errs++;
            tick();
        end
        check("partial_hidden_errs", errs, 0);
        push(16'h0C04, 1'b1);
        check("partial_empty_at_commit", empty, 1'b1);
        check("partial_count_at_commit", pkt_count, 8'd1);
        tick();
        pop_expect("partial_w0", 16'h0C01, 1'b0);
        pop_expect("partial_w1", 16'h0C02, 1'b0);
        pop_expect("partial_w2", 16'h0C03, 1'b0);
        pop_expect("partial_w3", 16'h0C04, 1'b1);
        check("partial_drained_empty", empty, 1'b1);
        check("partial_drained_count", pkt_count, 8'd0);

        // Fill with no pops: 1023 words fit in RAM plus one held in the output register.
        do_reset();
        acc = 0;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            din = 16'(acc); din_pkt_end = fill_pe(acc); din_empty = 1'b0;
            #1;
            if (!din_rd_en) break;
            tick();
            acc++;
        end
        check("fill_accepted_words", acc, 1024);
        check("fill_din_rd_en_low", din_rd_en, 1'b0);
        check("fill_pkt_count", pkt_count, 8'd3);
        check("fill_empty", empty, 1'b0);
        check("fill_first_dout", dout, 16'h0000);
        rd_en = 1'b1;
        tick();
        check("fill_reopen_din_rd_en", din_rd_en, 1'b1);
        din_empty = 1'b1;
        errs = 0;
        for (int i = 1; i < 1024; i++) begin
            if (empty !== 1'b0 || dout !== 16'(i) || dout_pkt_end !== fill_pe(i)) errs++;
            tick();
        end
        rd_en = 1'b0;
        check("fill_drain_errs", errs, 0);
        check("fill_drain_empty", empty, 1'b1);
        check("fill_drain_count", pkt_count, 8'd0);

        // 257 one-word packets: count saturates at 255, then floors at 0 on drain.
        do_reset();
        for (int i = 0; i < 257; i++) push(16'(i), 1'b1);
        check("sat_count_max", pkt_count, 8'd255);
        rd_en = 1'b1;
        errs = 0;
        for (int i = 0; i < 257; i++) begin
            if (empty !== 1'b0 || dout !== 16'(i)) errs++;
            tick();
        end
        rd_en = 1'b0;
        check("sat_drain_errs", errs, 0);
        check("sat_count_floor", pkt_count, 8'd0);

        // Wrap: 2000 words in 9-word packets with random source gaps and pops.
        do_reset();
        k = 0; popped = 0; mcnt = 0; errs = 0;
        for (int cyc = 0; cyc < 12000 && popped < 2000; cyc++) begin
            din_empty   = (k >= 2000) ? 1'b1 : ($urandom_range(3) == 0);
            din         = 16'(k * 37) ^ 16'h5A5A;
            din_pkt_end = (k % 9 == 8) || (k == 1999);
            rd_en       = 1'($urandom_range(1));
            #1;
            acc_now = din_rd_en;
            if (!empty && rd_en) begin
                if (q.size() == 0) begin
                    errs++;
                end else begin
                    exp_e = q.pop_front();
                    if ({dout_pkt_end, dout} !== exp_e) errs++;
                    if (exp_e[16]) mcnt--;
                end
                popped++;
            end
            if (acc_now) begin
                q.push_back({din_pkt_end, din});
                if (din_pkt_end) mcnt++;
                k++;
            end
            tick();
            if (pkt_count !== 8'(mcnt)) errs++;
        end
        din_empty = 1'b1; rd_en = 1'b0;
        check("wrap_words_in", k, 2000);
        check("wrap_words_out", popped, 2000);
        check("wrap_errs", errs, 0);
        check("wrap_end_empty", empty, 1'b1);
        check("wrap_end_count", pkt_count, 8'd0);

        // Reset while a word is presented and the next packet is half written.
        push(16'hD001, 1'b0);
        push(16'hD002, 1'b1);
        tick();
        check("rstmid_pre_valid", empty, 1'b0);
        push(16'hE001, 1'b0);
        push(16'hE002, 1'b0);
        rst = 1'b1; din = 16'hE003; din_empty = 1'b0;
        #1;
        check("rstmid_din_rd_en", din_rd_en, 1'b0);
        tick();
        check("rstmid_empty", empty, 1'b1);
        check("rstmid_count", pkt_count, 8'd0);
        check("rstmid_dout", dout, 16'h0000);
        check("rstmid_dout_pkt_end", dout_pkt_end, 1'b0);
        rst = 1'b0; din_empty = 1'b1;
        push(16'hF001, 1'b0);
        push(16'hF002, 1'b0);
        push(16'hF003, 1'b1);
        tick();
        pop_expect("rstmid_w0", 16'hF001, 1'b0);
        pop_expect("rstmid_w1", 16'hF002, 1'b0);
        pop_expect("rstmid_w2", 16'hF003, 1'b1);
        check("rstmid_end_empty", empty, 1'b1);
        check("rstmid_end_count", pkt_count, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
